// File: rtl/jtrthunder_colmix_if.sv
// jtrthunder_colmix_if
//   Bundles the pixel-rate signals of the colour mixer: timer blanking,
//   the three layer pixels with their priorities, the colour PROM
//   address/data pair, the debug layer enables and the final RGB outputs.
//   Modports:
//     slave  - the mixer itself (consumes layers/PROM data, drives RGB)
//     master - the surrounding video top (drives layers/PROM data, reads RGB)
interface jtrthunder_colmix_if;
  logic       pxl_cen;
  logic       lhbl;
  logic       lvbl;
  logic [7:0] scr0_pxl;
  logic [2:0] scr0_prio;
  logic [7:0] scr1_pxl;
  logic [2:0] scr1_prio;
  logic [7:0] obj_pxl;
  logic [2:0] obj_prio;
  logic [8:0] pal_addr;
  logic [7:0] pal_rg;
  logic [3:0] pal_b;
  logic [3:0] gfx_en;
  logic       lhbl_dly;
  logic       lvbl_dly;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;

  modport slave (
    input  pxl_cen, lhbl, lvbl,
    input  scr0_pxl, scr0_prio, scr1_pxl, scr1_prio, obj_pxl, obj_prio,
    input  pal_rg, pal_b, gfx_en,
    output pal_addr, lhbl_dly, lvbl_dly, red, green, blue
  );

  modport master (
    output pxl_cen, lhbl, lvbl,
    output scr0_pxl, scr0_prio, scr1_pxl, scr1_prio, obj_pxl, obj_prio,
    output pal_rg, pal_b, gfx_en,
    input  pal_addr, lhbl_dly, lvbl_dly, red, green, blue
  );
endinterface

// File: rtl/jtrthunder_colmix.sv
// jtrthunder_colmix
//   Final colour mixer. Per pixel it picks the winning layer among scroll 0,
//   scroll 1 and sprites, addresses the colour PROM with the winning index,
//   then expands the returned 4-bit components to 8 bits and applies blanking.
//   Two pxl_cen stages: S1 registers the PROM address and blanking copies,
//   S2 registers RGB and the delayed blanking outputs.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset, clears every register
//   bus    - jtrthunder_colmix_if.slave (layers, PROM, blanking, RGB)
// Parameters:
//   BGCOL  - palette index used when every layer is transparent/disabled
// Optional build macro:
//   JTRTHUNDER_SHADOW_EN - sprite colour 4'hE becomes a shadow that darkens
//                          the layer beneath it instead of being drawn.
module jtrthunder_colmix #(
  parameter logic [8:0] BGCOL = 9'h100
) (
  input logic                  clk,
  input logic                  rst_n,
  jtrthunder_colmix_if.slave   bus
);

  logic       w_scr0_op;
  logic       w_scr1_op;
  logic       w_obj_op;
  logic       w_obj_shd;
  logic       w_obj_win;
  logic       w_shadow;
  logic       w_scr_found;
  logic [2:0] w_scr_prio;
  logic [8:0] w_scr_idx;
  logic [8:0] w_idx;

  logic [8:0] r_pal_addr;
  logic       r_blank_s1;
  logic       r_lhbl_s1;
  logic       r_lvbl_s1;
  logic       r_shadow_s1;
  logic [7:0] r_red;
  logic [7:0] r_green;
  logic [7:0] r_blue;
  logic       r_lhbl_dly;
  logic       r_lvbl_dly;

  assign w_scr0_op = bus.gfx_en[0] && (bus.scr0_pxl[2:0] != 3'h7);
  assign w_scr1_op = bus.gfx_en[1] && (bus.scr1_pxl[2:0] != 3'h7);
  assign w_obj_op  = bus.gfx_en[3] && (bus.obj_pxl[3:0]  != 4'hF);

`ifdef JTRTHUNDER_SHADOW_EN
  assign w_obj_shd = (bus.obj_pxl[3:0] == 4'hE);
`else
  assign w_obj_shd = 1'b0;
`endif

  // Scroll-only winner; scr0 takes ties against scr1
  always_comb begin
    w_scr_found = 1'b0;
    w_scr_prio  = 3'd0;
    w_scr_idx   = BGCOL;
    if (w_scr0_op && (!w_scr1_op || (bus.scr0_prio >= bus.scr1_prio))) begin
      w_scr_found = 1'b1;
      w_scr_prio  = bus.scr0_prio;
      w_scr_idx   = {1'b0, bus.scr0_pxl};
    end else if (w_scr1_op) begin
      w_scr_found = 1'b1;
      w_scr_prio  = bus.scr1_prio;
      w_scr_idx   = {1'b0, bus.scr1_pxl};
    end else begin
      w_scr_found = 1'b0;
    end
  end

  // Sprite wins ties against both scrolls; a shadow sprite that would win
  // hands the pixel to the scroll winner (or backdrop) and flags darkening
  assign w_obj_win = w_obj_op && (!w_scr_found || (bus.obj_prio >= w_scr_prio));
  assign w_shadow  = w_obj_win && w_obj_shd;

  // Final palette index selection
  always_comb begin
    w_idx = BGCOL;
    if (w_obj_win && !w_shadow) begin
      w_idx = {1'b1, bus.obj_pxl};
    end else if (w_scr_found) begin
      w_idx = w_scr_idx;
    end else begin
      w_idx = BGCOL;
    end
  end

  // S1: register PROM address, blanking state and shadow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pal_addr  <= 9'd0;
      r_blank_s1  <= 1'b0;
      r_lhbl_s1   <= 1'b0;
      r_lvbl_s1   <= 1'b0;
      r_shadow_s1 <= 1'b0;
    end else if (bus.pxl_cen) begin
      r_pal_addr  <= w_idx;
      r_blank_s1  <= ~(bus.lhbl & bus.lvbl);
      r_lhbl_s1   <= bus.lhbl;
      r_lvbl_s1   <= bus.lvbl;
      r_shadow_s1 <= w_shadow;
    end
  end

  // S2: expand PROM nibbles to 8 bits, apply shadow and blanking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_red      <= 8'd0;
      r_green    <= 8'd0;
      r_blue     <= 8'd0;
      r_lhbl_dly <= 1'b0;
      r_lvbl_dly <= 1'b0;
    end else if (bus.pxl_cen) begin
      r_lhbl_dly <= r_lhbl_s1;
      r_lvbl_dly <= r_lvbl_s1;
      if (r_blank_s1) begin
        r_red   <= 8'd0;
        r_green <= 8'd0;
        r_blue  <= 8'd0;
      end else if (r_shadow_s1) begin
        // half brightness: {c,c} >> 1
        r_red   <= {1'b0, bus.pal_rg[7:4], bus.pal_rg[7:5]};
        r_green <= {1'b0, bus.pal_rg[3:0], bus.pal_rg[3:1]};
        r_blue  <= {1'b0, bus.pal_b,       bus.pal_b[3:1]};
      end else begin
        r_red   <= {bus.pal_rg[7:4], bus.pal_rg[7:4]};
        r_green <= {bus.pal_rg[3:0], bus.pal_rg[3:0]};
        r_blue  <= {bus.pal_b,       bus.pal_b};
      end
    end
  end

  assign bus.pal_addr = r_pal_addr;
  assign bus.red      = r_red;
  assign bus.green    = r_green;
  assign bus.blue     = r_blue;
  assign bus.lhbl_dly = r_lhbl_dly;
  assign bus.lvbl_dly = r_lvbl_dly;

endmodule

// File: doc/jtrthunder_colmix.md
Name: jtrthunder_colmix

Overview:
- Colour mixer stage directly downstream of the video timer and the tile/sprite layer generators; drives the final RGB outputs of the video top.
- Each pixel: resolves priority between two scroll layers and the sprite layer, looks up the winning colour index in the external colour PROMs, expands 4-bit components to 8 bits and applies blanking.
- Everything advances on pxl_cen; blanking outputs are delayed to stay aligned with RGB.

Parameters:
- BGCOL, 9'h100, palette index used when every layer is transparent or disabled.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- pxl_cen  in  1  pixel clock enable; never asserted on two consecutive clk cycles
- lhbl  in  1  horizontal blank from timer, active low
- lvbl  in  1  vertical blank from timer, active low
- scr0_pxl  in  8  scroll layer 0 colour index
- scr0_prio  in  3  scroll layer 0 priority
- scr1_pxl  in  8  scroll layer 1 colour index
- scr1_prio  in  3  scroll layer 1 priority
- obj_pxl  in  8  sprite colour index
- obj_prio  in  3  sprite priority
- pal_addr  out  9  colour PROM address, registered
- pal_rg  in  8  PROM data {R[3:0],G[3:0]}, valid one clk after pal_addr changes
- pal_b  in  4  PROM data, blue nibble, same timing as pal_rg
- gfx_en  in  4  debug layer enables: bit0 scr0, bit1 scr1, bit3 obj; bit2 unused
- lhbl_dly  out  1  lhbl delayed to match RGB
- lvbl_dly  out  1  lvbl delayed to match RGB
- red, green, blue  out  8 each  final colour

Behaviour:
- Reset: async on rst_n low; all outputs (pal_addr, red, green, blue, lhbl_dly, lvbl_dly) and all internal pipeline registers go to 0.
- Transparency:
  - Scroll pixel is transparent when pxl[2:0]==3'h7.
  - Sprite pixel is transparent when obj_pxl[3:0]==4'hF.
  - A layer whose gfx_en bit is 0 is treated as transparent.
- Priority:
  - The opaque layer with the numerically highest prio wins.
  - Ties resolve sprite > scr0 > scr1.
  - If all layers are transparent, the index is BGCOL.
- Palette index: scroll winner gives {1'b0, pxl}; sprite winner gives {1'b1, obj_pxl}.
- Stage S1 (pxl_cen edge N):
  - Sample inputs and compute the winner.
  - pal_addr <= index.
  - Register blank_s1 = ~(lhbl & lvbl), plus lhbl and lvbl copies.
- PROM read: combinational/synchronous external memory; data valid at least 1 clk before the next pxl_cen, which the pxl_cen spacing guarantees.
- Stage S2 (pxl_cen edge N+1):
  - If blank_s1: red/green/blue <= 0.
  - Else each 4-bit component c expands to {c,c} (4'hA -> 8'hAA).
  - lhbl_dly/lvbl_dly <= S1 copies.
- Latency: input sampled at edge N appears on RGB and the *_dly outputs after edge N+1, i.e. 2 pxl_cen edges.
- Without pxl_cen all registers hold.
- Timer signals at the blanking boundary have no special handling: the last active pixel is coloured and the first blanked pixel is black, exactly 2 cen later.
- Reset mid-frame: outputs go black immediately; the pipeline refills within 2 pxl_cen after release.

Optional Feature:
- Macro JTRTHUNDER_SHADOW_EN.
- With macro defined:
  - An opaque-priority sprite pixel with obj_pxl[3:0]==4'hE is a shadow. It does not win; priority resolves among the remaining layers (or BGCOL).
  - A shadow flag is registered through S1 only when the shadow sprite would have won under normal rules.
  - In S2, each 8-bit component is shifted right by 1 when the flag is set (8'hAA -> 8'h55).
  - Blanking still forces 0.
- Without macro: 4'hE is an ordinary opaque sprite colour and no shadow logic is generated.

Test Plan:
- Reset and recovery: rst_n low mid-stream -> RGB, pal_addr, *_dly all 0 asynchronously; after release, first valid RGB 2 pxl_cen later.
- Priority win:
  - Input: scr0 (0x12, prio 3), scr1 (0x34, prio 5), obj (0x56, prio 5).
  - Expected: pal_addr=9'h156. With pal_rg=8'h9C and pal_b=4'h3, RGB=99/CC/33 after 2nd cen.
- Transparency and backdrop:
  - Input: scr0=0x07, scr1=0x1F, obj=0xFF.
  - Expected: pal_addr=9'h100.
  - Then set gfx_en=4'b0000 with opaque inputs -> pal_addr=9'h100.
- Blanking alignment: lhbl low for 1 pixel with opaque inputs -> RGB 0 and lhbl_dly low on exactly the same cycle, 2 pxl_cen after input.
- Tie rule: scr0 (0x20, prio 2) and scr1 (0x40, prio 2), obj transparent -> pal_addr=9'h020.
- Shadow (JTRTHUNDER_SHADOW_EN):
  - Input: obj 0x0E prio 7 over scr1 0x40 prio 1, PROM gives RGB AA/AA/AA.
  - Expected: pal_addr=9'h040, output 55/55/55.
  - Without the macro: pal_addr=9'h10E.
